// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: per-channel divided clock, tick strobe and pending-ratio flag.
// All outputs are registered and change one clk_in edge after their cause; there is no handshake and the block never stalls.
module clk_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    logic [CNT_W-1:0]  r_div   [NUM_CH];
    logic [CNT_W-1:0]  r_cnt   [NUM_CH];
    logic [CNT_W-1:0]  r_pdiv  [NUM_CH];
    logic [NUM_CH-1:0] r_pvld;
    logic [NUM_CH-1:0] r_clk;
    logic [NUM_CH-1:0] r_tick;

    logic [CNT_W-1:0]  w_div_n  [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_n  [NUM_CH];
    logic [CNT_W-1:0]  w_pdiv_n [NUM_CH];
    logic [CNT_W:0]    w_half   [NUM_CH];
    logic [NUM_CH-1:0] w_pvld_n;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_restart;
    logic [NUM_CH-1:0] w_clk_n;
    logic [NUM_CH-1:0] w_tick_n;

    always_comb begin
        w_pvld_n  = r_pvld;
        w_hit     = '0;
        w_restart = '0;
        w_clk_n   = '0;
        w_tick_n  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_div_n[i]  = r_div[i];
            w_cnt_n[i]  = r_cnt[i];
            w_pdiv_n[i] = r_pdiv[i];
            w_hit[i]    = cfg_wr && (cfg_ch == CH_W'(i));

            if (sync) begin
                // A write in the sync cycle overrides any older pending ratio.
                if (w_hit[i]) begin
                    w_div_n[i] = cfg_div;
                end else if (r_pvld[i]) begin
                    w_div_n[i] = r_pdiv[i];
                end
                w_pvld_n[i]  = 1'b0;
                w_restart[i] = 1'b1;
            end else if (r_div[i] == '0) begin
                if (w_hit[i]) begin
                    w_div_n[i]   = cfg_div;
                    w_pvld_n[i]  = 1'b0;
                    w_restart[i] = 1'b1;
                end else if (r_pvld[i]) begin
                    w_div_n[i]   = r_pdiv[i];
                    w_pvld_n[i]  = 1'b0;
                    w_restart[i] = 1'b1;
                end
            end else if ((r_cnt[i] == '0) || (r_cnt[i] >= r_div[i])) begin
                // Period boundary: older pending ratio takes effect, a write landing now waits one period.
                if (r_pvld[i]) begin
                    w_div_n[i]  = r_pdiv[i];
                    w_pvld_n[i] = 1'b0;
                end
                if (w_hit[i]) begin
                    w_pdiv_n[i] = cfg_div;
                    w_pvld_n[i] = 1'b1;
                end
                w_restart[i] = 1'b1;
            end else begin
                w_cnt_n[i] = r_cnt[i] + ONE;
                if (w_hit[i]) begin
                    w_pdiv_n[i] = cfg_div;
                    w_pvld_n[i] = 1'b1;
                end
            end

            if (w_restart[i]) begin
                w_cnt_n[i] = (w_div_n[i] != '0) ? ONE : '0;
            end

            // One extra bit so D = 2^CNT_W-1 does not wrap when rounding up.
            w_half[i]   = ({1'b0, w_div_n[i]} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
            w_clk_n[i]  = (w_div_n[i] >= TWO) && (w_cnt_n[i] != '0)
                          && ({1'b0, w_cnt_n[i]} <= w_half[i]);
            w_tick_n[i] = (w_div_n[i] != '0) && (w_cnt_n[i] == w_div_n[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]  <= DEF_D;
                r_cnt[i]  <= '0;
                r_pdiv[i] <= '0;
            end
            r_pvld <= '0;
            r_clk  <= '0;
            r_tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]  <= w_div_n[i];
                r_cnt[i]  <= w_cnt_n[i];
                r_pdiv[i] <= w_pdiv_n[i];
            end
            r_pvld <= w_pvld_n;
            r_clk  <= w_clk_n;
            r_tick <= w_tick_n;
        end
    end

    assign clk_out     = r_clk;
    assign tick        = r_tick;
    assign cfg_pending = r_pvld;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi (3 channels, 4-bit ratios): directed scenarios plus randomized traffic vs a period/phase model.
module tb_clk_divider_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 4;
    localparam int DEF    = 2;

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b1;
    logic             cfg_wr = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             sync   = 1'b0;
    logic [NUM_CH-1:0] clk_out, tick, cfg_pending;

    int n_checks = 0;
    int n_errors = 0;

    // Model: active ratio, 0-based position within the current period, running flag, pending ratio.
    int m_d  [NUM_CH];
    int m_p  [NUM_CH];
    int m_pd [NUM_CH];
    bit m_run[NUM_CH];
    bit m_has[NUM_CH];
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;

    clk_divider_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .sync(sync), .clk_out(clk_out), .tick(tick),
        .cfg_pending(cfg_pending)
    );

    initial forever #5 clk_in = ~clk_in;

    function automatic void m_outputs();
        for (int c = 0; c < NUM_CH; c++) begin
            bit act;
            act       = m_run[c] && (m_d[c] != 0);
            e_clk[c]  = act && (m_d[c] >= 2) && (m_p[c] < (m_d[c] + 1) / 2);
            e_tick[c] = act && (m_p[c] == m_d[c] - 1);
            e_pend[c] = m_has[c];
        end
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_d[c] = DEF; m_p[c] = 0; m_pd[c] = 0; m_run[c] = 0; m_has[c] = 0;
        end
        m_outputs();
    endtask

    task automatic drive(input bit wr, input int ch, input int dv, input bit sy);
        cfg_wr  = wr;
        cfg_ch  = 2'(ch);
        cfg_div = CNT_W'(dv);
        sync    = sy;
    endtask

    // Advance one clk_in cycle and move the model by the inputs sampled at that edge.
    task automatic step();
        bit s_wr, s_sync;
        int s_ch, s_div;
        s_wr = cfg_wr; s_sync = sync; s_ch = int'(cfg_ch); s_div = int'(cfg_div);
        @(posedge clk_in);
        for (int c = 0; c < NUM_CH; c++) begin
            bit hit, restart;
            hit = s_wr && (s_ch == c);
            restart = 0;
            if (s_sync) begin
                if (hit) m_d[c] = s_div;
                else if (m_has[c]) m_d[c] = m_pd[c];
                m_has[c] = 0;
                restart = 1;
            end else if (m_d[c] == 0) begin
                if (hit) begin
                    m_d[c] = s_div; m_has[c] = 0; restart = 1;
                end else if (m_has[c]) begin
                    m_d[c] = m_pd[c]; m_has[c] = 0; restart = 1;
                end
            end else if (!m_run[c] || m_p[c] == m_d[c] - 1) begin
                if (m_has[c]) begin
                    m_d[c] = m_pd[c]; m_has[c] = 0;
                end
                if (hit) begin
                    m_pd[c] = s_div; m_has[c] = 1;
                end
                restart = 1;
            end else begin
                m_p[c]++;
                if (hit) begin
                    m_pd[c] = s_div; m_has[c] = 1;
                end
            end
            if (restart) begin
                m_p[c] = 0;
                m_run[c] = (m_d[c] != 0);
            end
        end
        m_outputs();
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if ({clk_out, tick, cfg_pending} !== 9'b0) begin
            n_errors++;
            $display("FAIL reset_async: got %b required 0", {clk_out, tick, cfg_pending});
        end
        @(negedge clk_in); @(negedge clk_in);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            logic [8:0] req;
            step();
            req = (k % 2 == 1) ? {3'b111, 3'b000, 3'b000} : {3'b000, 3'b111, 3'b000};
            n_checks++;
            if ({clk_out, tick, cfg_pending} !== req) begin
                n_errors++;
                $display("FAIL reset_default_div cyc %0d: got %b required %b", k, {clk_out, tick, cfg_pending}, req);
            end
        end
    endtask

    task automatic test_ratio_change();
        step();
        drive(1, 1, 5, 0);
        step();
        drive(0, 0, 0, 0);
        n_checks++;
        if ({clk_out[1], tick[1], cfg_pending[1]} !== 3'b011) begin
            n_errors++;
            $display("FAIL ratio_change_old_period: got %b required 011", {clk_out[1], tick[1], cfg_pending[1]});
        end
        for (int k = 1; k <= 5; k++) begin
            logic [2:0] req;
            step();
            req = {1'(k <= 3), 1'(k == 5), 1'b0};
            n_checks++;
            if ({clk_out[1], tick[1], cfg_pending[1]} !== req) begin
                n_errors++;
                $display("FAIL ratio_change_d5 cyc %0d: got %b required %b", k, {clk_out[1], tick[1], cfg_pending[1]}, req);
            end
            n_checks++;
            if ({clk_out, tick, cfg_pending} !== {e_clk, e_tick, e_pend}) begin
                n_errors++;
                $display("FAIL ratio_change_model cyc %0d: got %b required %b", k, {clk_out, tick, cfg_pending}, {e_clk, e_tick, e_pend});
            end
        end
    endtask

    task automatic test_div_one_disable();
        drive(1, 2, 1, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if ({clk_out[2], tick[2], cfg_pending[2]} !== 3'b010) begin
                n_errors++;
                $display("FAIL div_one cyc %0d: got %b required 010", k, {clk_out[2], tick[2], cfg_pending[2]});
            end
            step();
        end
        drive(1, 2, 0, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if ({clk_out[2], tick[2], cfg_pending[2]} !== 3'b000) begin
                n_errors++;
                $display("FAIL div_zero cyc %0d: got %b required 000", k, {clk_out[2], tick[2], cfg_pending[2]});
            end
            step();
        end
        drive(1, 2, 4, 0);
        step();
        drive(0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] req;
            req = {1'(((k - 1) % 4) < 2), 1'(k % 4 == 0), 1'b0};
            n_checks++;
            if ({clk_out[2], tick[2], cfg_pending[2]} !== req) begin
                n_errors++;
                $display("FAIL reenable_d4 cyc %0d: got %b required %b", k, {clk_out[2], tick[2], cfg_pending[2]}, req);
            end
            step();
        end
    endtask

    task automatic test_sync();
        drive(1, 0, 3, 0);
        step();
        drive(1, 2, 7, 0);
        step();
        drive(0, 0, 0, 0);
        repeat ($urandom_range(0, 5)) step();
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            logic [5:0] req;
            req = {1'(((k - 1) % 3) < 2), 1'(k % 3 == 0), 1'b0,
                   1'(((k - 1) % 7) < 4), 1'(k % 7 == 0), 1'b0};
            n_checks++;
            if ({clk_out[0], tick[0], cfg_pending[0], clk_out[2], tick[2], cfg_pending[2]} !== req) begin
                n_errors++;
                $display("FAIL sync_align cyc %0d: got %b required %b", k,
                         {clk_out[0], tick[0], cfg_pending[0], clk_out[2], tick[2], cfg_pending[2]}, req);
            end
            step();
        end
    endtask

    task automatic test_out_of_range_last_write();
        drive(1, 3, 6, 0);
        step();
        drive(0, 0, 0, 0);
        n_checks++;
        if (cfg_pending !== 3'b000) begin
            n_errors++;
            $display("FAIL out_of_range_pending: got %b required 000", cfg_pending);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if ({clk_out, tick, cfg_pending} !== {e_clk, e_tick, e_pend}) begin
                n_errors++;
                $display("FAIL out_of_range_model cyc %0d: got %b required %b", k, {clk_out, tick, cfg_pending}, {e_clk, e_tick, e_pend});
            end
        end
        drive(1, 1, 5, 1);
        step();
        drive(1, 1, 6, 0);
        step();
        drive(1, 1, 9, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        n_checks++;
        if ({tick[1], cfg_pending[1]} !== 2'b11) begin
            n_errors++;
            $display("FAIL last_write_pending: got %b required 11", {tick[1], cfg_pending[1]});
        end
        for (int k = 1; k <= 9; k++) begin
            logic [2:0] req;
            step();
            req = {1'(k <= 5), 1'(k == 9), 1'b0};
            n_checks++;
            if ({clk_out[1], tick[1], cfg_pending[1]} !== req) begin
                n_errors++;
                $display("FAIL last_write_d9 cyc %0d: got %b required %b", k, {clk_out[1], tick[1], cfg_pending[1]}, req);
            end
        end
    endtask

    task automatic test_max_div();
        drive(1, 0, 15, 1);
        step();
        drive(0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            logic [1:0] req;
            req = {1'(((k - 1) % 15) < 8), 1'(k == 15)};
            n_checks++;
            if ({clk_out[0], tick[0]} !== req) begin
                n_errors++;
                $display("FAIL max_div cyc %0d: got %b required %b", k, {clk_out[0], tick[0]}, req);
            end
            step();
        end
    endtask

    task automatic test_reset_pending();
        drive(1, 0, 9, 0);
        step();
        drive(0, 0, 0, 0);
        n_checks++;
        if (cfg_pending[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_pending_set: got %b required 1", cfg_pending[0]);
        end
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if ({clk_out, tick, cfg_pending} !== 9'b0) begin
            n_errors++;
            $display("FAIL reset_midperiod: got %b required 0", {clk_out, tick, cfg_pending});
        end
        @(posedge clk_in); @(posedge clk_in); #1;
        n_checks++;
        if ({clk_out, tick, cfg_pending} !== 9'b0) begin
            n_errors++;
            $display("FAIL reset_held: got %b required 0", {clk_out, tick, cfg_pending});
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            logic [8:0] req;
            step();
            req = (k % 2 == 1) ? {3'b111, 3'b000, 3'b000} : {3'b000, 3'b111, 3'b000};
            n_checks++;
            if ({clk_out, tick, cfg_pending} !== req) begin
                n_errors++;
                $display("FAIL reset_release cyc %0d: got %b required %b", k, {clk_out, tick, cfg_pending}, req);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15)),
                  $urandom_range(0, 24) == 0);
            step();
            n_checks++;
            if ({clk_out, tick, cfg_pending} !== {e_clk, e_tick, e_pend}) begin
                n_errors++;
                $display("FAIL random cyc %0d: got %b required %b", k, {clk_out, tick, cfg_pending}, {e_clk, e_tick, e_pend});
            end
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_ratio_change();
        test_div_one_disable();
        test_sync();
        test_out_of_range_last_write();
        test_max_div();
        test_reset_pending();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
